cond_logic: RTL and testbench
=============================

COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 SHALL have port: Cond  input  4  condition field, Instr[31:28].
REQ-004 SHALL have port: ALUFlags  input  4  ALU result flags {N,Z,C,V}.
REQ-005 SHALL have port: FlagW  input  2  flag-write request from decode; [1]=N,Z, [0]=C,V.
REQ-006 SHALL have port: PCS, RegW, MemW  input  1 each  ungated PC, register and memory write requests from decode.
REQ-007 SHALL have port: NextPC  input  1  fetch-cycle PC update from mainfsm.
REQ-008 SHALL have port: CondLatch  input  1  single-cycle strobe from mainfsm in the Decode state.
REQ-009 SHALL have port: CntClr  input  1  synchronous clear of the statistics counters.
REQ-010 SHALL have port: PCWrite, RegWrite, MemWrite  output  1 each  gated write enables to the datapath.
REQ-011 SHALL have port: Flags  output  4  current architectural {N,Z,C,V}.
REQ-012 SHALL have port: ExecCnt, AnnulCnt  output  16 each  executed and annulled instruction counts.

Function
REQ-013 SHALL decode Cond combinationally against the Flags register: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0 (annulled).
REQ-014 SHALL load the decoded result into a CondEx register on the rising edge where CondLatch=1; CondEx holds otherwise.
REQ-015 SHALL produce RegWrite=RegW&CondEx, MemWrite=MemW&CondEx, PCWrite=(PCS&CondEx)|NextPC, all combinational with zero latency.
REQ-016 SHALL never gate NextPC; fetch PC update proceeds regardless of CondEx.
REQ-017 SHALL update N,Z from ALUFlags[3:2] when FlagW[1]&CondEx, and C,V from ALUFlags[1:0] when FlagW[0]&CondEx, at the clock edge.
REQ-018 SHALL evaluate CondLatch against pre-edge flags when a flag write and CondLatch occur in the same cycle.
REQ-019 SHALL increment ExecCnt on CondLatch with decoded condition true, AnnulCnt on CondLatch with condition false; exactly one counter per strobe.
REQ-020 SHALL saturate each counter at 16'hFFFF; no wrap-around.
REQ-021 SHALL give CntClr priority over increment: CntClr and CondLatch together leave both counters 0; CondEx and flags still update normally.
REQ-022 SHALL drive Flags directly from the flag registers.

Reset
REQ-023 SHALL on reset=0 asynchronously clear Flags to 4'b0000, CondEx to 0, ExecCnt and AnnulCnt to 0; RegWrite=MemWrite=0 and PCWrite=NextPC while in reset.
REQ-024 SHALL resume on the first rising clk edge after reset deasserts; reset during an execute cycle discards the instruction (no flag or counter update).

Structure
REQ-025 SHALL place condition-code constants (EQ..AL, NV) and flag bit positions (N=3,Z=2,C=1,V=0) in the shared arm_pkg package.
REQ-026 SHALL implement the condition decoder as sub-module cond_check (Cond, Flags -> CondEx_next), purely combinational.
REQ-027 SHALL implement all registers in cond_logic; cond_logic is instantiated in controller alongside decode.

Verification
REQ-028 SHALL verify: Flags=0000, Cond=0000, CondLatch pulse, RegW=1 -> CondEx=0, RegWrite=0, AnnulCnt=1.
REQ-029 SHALL verify: FlagW=11, ALUFlags=0100 under AL -> Flags=0100; next Cond=0000 latch, RegW=1 -> RegWrite=1, ExecCnt increments.
REQ-030 SHALL verify: all 16 Cond values over all 16 Flags values match REQ-013 table (256 checks).
REQ-031 SHALL verify: same-cycle FlagW=10 (Z 0->1) and CondLatch with Cond=0000 -> CondEx=0.
REQ-032 SHALL verify: 65540 AL latches -> ExecCnt=FFFF held; CntClr with CondLatch -> 0 next cycle.
REQ-033 SHALL verify: reset=0 asserted mid-execute with MemW=1 -> MemWrite=0 immediately, Flags=0000, counters 0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared ARM control definitions: condition-code encodings, flag bit positions
// and the saturating counter helper used by the condition logic.
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned CNT_W = 16;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition decoder: evaluates Cond against the {N,Z,C,V} flags.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx_next
);

    logic n, z, c, v;

    always_comb begin
        n = Flags[FLAG_N];
        z = Flags[FLAG_Z];
        c = Flags[FLAG_C];
        v = Flags[FLAG_V];
    end

    always_comb begin
        CondEx_next = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx_next = z;
            COND_NE: CondEx_next = ~z;
            COND_CS: CondEx_next = c;
            COND_CC: CondEx_next = ~c;
            COND_MI: CondEx_next = n;
            COND_PL: CondEx_next = ~n;
            COND_VS: CondEx_next = v;
            COND_VC: CondEx_next = ~v;
            COND_HI: CondEx_next = c & ~z;
            COND_LS: CondEx_next = ~c | z;
            COND_GE: CondEx_next = (n == v);
            COND_LT: CondEx_next = (n != v);
            COND_GT: CondEx_next = ~z & (n == v);
            COND_LE: CondEx_next = z | (n != v);
            COND_AL: CondEx_next = 1'b1;
            COND_NV: CondEx_next = 1'b0;
            default: CondEx_next = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: latches the condition result at decode, gates
// datapath write enables, owns the architectural flags and execute statistics.
module cond_logic
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    input  logic        NextPC,
    input  logic        CondLatch,
    input  logic        CntClr,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  Flags,
    output logic [15:0] ExecCnt,
    output logic [15:0] AnnulCnt
);

    logic [3:0]       flags_q, flags_d;
    logic             condex_q, condex_d;
    logic [CNT_W-1:0] exec_q, exec_d;
    logic [CNT_W-1:0] annul_q, annul_d;
    logic             cond_next;

    // Decoder sees the pre-edge flags, so a same-cycle flag write does not
    // affect the instruction being latched.
    cond_check u_cond_check (
        .Cond        (Cond),
        .Flags       (flags_q),
        .CondEx_next (cond_next)
    );

    always_comb begin
        flags_d = flags_q;
        if (FlagW[1] & condex_q) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (FlagW[0] & condex_q) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
    end

    always_comb begin
        condex_d = condex_q;
        if (CondLatch) begin
            condex_d = cond_next;
        end
    end

    always_comb begin
        exec_d  = exec_q;
        annul_d = annul_q;
        if (CntClr) begin
            exec_d  = '0;
            annul_d = '0;
        end else if (CondLatch) begin
            if (cond_next) begin
                exec_d = sat_inc(exec_q);
            end else begin
                annul_d = sat_inc(annul_q);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q  <= '0;
            condex_q <= 1'b0;
            exec_q   <= '0;
            annul_q  <= '0;
        end else begin
            flags_q  <= flags_d;
            condex_q <= condex_d;
            exec_q   <= exec_d;
            annul_q  <= annul_d;
        end
    end

    // NextPC bypasses the condition so fetch always advances.
    always_comb begin
        RegWrite = RegW & condex_q;
        MemWrite = MemW & condex_q;
        PCWrite  = (PCS & condex_q) | NextPC;
    end

    always_comb begin
        Flags    = flags_q;
        ExecCnt  = exec_q;
        AnnulCnt = annul_q;
    end

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: a reference model pushes expected outputs
// when stimulus is driven; each scenario task pops and compares after the edge.
module tb_cond_logic;

    logic        clk;
    logic        reset;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, RegW, MemW, NextPC, CondLatch, CntClr;
    logic        PCWrite, RegWrite, MemWrite;
    logic [3:0]  Flags;
    logic [15:0] ExecCnt, AnnulCnt;

    cond_logic dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NextPC    (NextPC),
        .CondLatch (CondLatch),
        .CntClr    (CntClr),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .Flags     (Flags),
        .ExecCnt   (ExecCnt),
        .AnnulCnt  (AnnulCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite, RegWrite, MemWrite, Flags, ExecCnt, AnnulCnt}
    logic [38:0] exp_q[$];
    int n_vec;
    int n_err;

    logic [3:0]  m_flags;
    logic        m_condex;
    logic [15:0] m_exec, m_annul;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [38:0] observed();
        return {PCWrite, RegWrite, MemWrite, Flags, ExecCnt, AnnulCnt};
    endfunction

    function automatic logic [38:0] model_out();
        return {(PCS & m_condex) | NextPC, RegW & m_condex, MemW & m_condex,
                m_flags, m_exec, m_annul};
    endfunction

    // Drive one cycle at the negedge, advance the model across the next
    // posedge, optionally push the expected post-edge outputs, then wait.
    task automatic step(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                        input logic pcs_v, input logic regw_v, input logic memw_v,
                        input logic npc_v, input logic lat, input logic clr, input bit push);
        logic       ok;
        logic [3:0] nf;
        Cond = c; ALUFlags = alu; FlagW = fw; PCS = pcs_v; RegW = regw_v;
        MemW = memw_v; NextPC = npc_v; CondLatch = lat; CntClr = clr;
        ok = cond_ok(c, m_flags);
        nf = m_flags;
        if (fw[1] && m_condex) nf[3:2] = alu[3:2];
        if (fw[0] && m_condex) nf[1:0] = alu[1:0];
        if (clr) begin
            m_exec = '0; m_annul = '0;
        end else if (lat) begin
            if (ok) m_exec = (m_exec == 16'hFFFF) ? m_exec : m_exec + 16'd1;
            else    m_annul = (m_annul == 16'hFFFF) ? m_annul : m_annul + 16'd1;
        end
        if (lat) m_condex = ok;
        m_flags = nf;
        if (push) exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [38:0] got, e;
        reset = 1'b0;
        Cond = 4'd14; ALUFlags = 4'hF; FlagW = 2'b11;
        PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NextPC = 1'b1; CondLatch = 1'b1; CntClr = 1'b0;
        m_flags = '0; m_condex = 1'b0; m_exec = '0; m_annul = '0;
        exp_q.push_back(model_out());
        @(negedge clk);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL reset_npc1: got %h expected %h", got, e);
        end
        NextPC = 1'b0;
        exp_q.push_back(model_out());
        #1;
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL reset_npc0: got %h expected %h", got, e);
        end
        Cond = '0; ALUFlags = '0; FlagW = '0; PCS = 0; RegW = 0; MemW = 0; CondLatch = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_annul_eq();
        logic [38:0] got, e;
        step(4'd0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL annul_eq: got %h expected %h", got, e);
        end
    endtask

    task automatic test_flag_exec();
        logic [38:0] got, e;
        step(4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'd14, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL flag_write: got %h expected %h", got, e);
        end
        step(4'd0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL exec_eq: got %h expected %h", got, e);
        end
    endtask

    task automatic test_write_gating();
        logic [38:0] got, e;
        // NV annuls: PCS, RegW, MemW all suppressed, NextPC still passes.
        step(4'd15, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL gate_annul: got %h expected %h", got, e);
        end
        step(4'd15, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL gate_nextpc: got %h expected %h", got, e);
        end
        // Annulled instruction must not write flags.
        step(4'd14, 4'hA, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL gate_flags: got %h expected %h", got, e);
        end
        step(4'd14, 4'h0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL gate_exec: got %h expected %h", got, e);
        end
        // Partial flag write: only C,V change.
        step(4'd14, 4'hB, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL flagw_cv: got %h expected %h", got, e);
        end
    endtask

    task automatic test_cond_table();
        logic [38:0] got, e;
        for (int f = 0; f < 16; f++) begin
            step(4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            step(4'd14, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 16; c++) begin
                step(4'(c), 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
                got = observed(); e = exp_q.pop_front(); n_vec++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL cond_table c=%0d f=%h: got %h expected %h", c, f[3:0], got, e);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [38:0] got, e;
        step(4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'd14, 4'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Z goes 0->1 on the same edge EQ is latched; EQ sees Z=0.
        step(4'd0, 4'h4, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL same_cycle: got %h expected %h", got, e);
        end
    endtask

    task automatic test_saturate();
        logic [38:0] got, e;
        step(4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL cnt_clear: got %h expected %h", got, e);
        end
        for (int i = 0; i < 65540; i++) begin
            step(4'd14, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (i == 65539));
        end
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL cnt_saturate: got %h expected %h", got, e);
        end
        step(4'd14, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL clr_priority: got %h expected %h", got, e);
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [38:0] got, e;
        step(4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(4'd14, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        Cond = 4'd14; ALUFlags = 4'h6; FlagW = 2'b11; PCS = 1'b0; RegW = 1'b0;
        MemW = 1'b1; NextPC = 1'b1; CondLatch = 1'b1; CntClr = 1'b0;
        #2;
        reset = 1'b0;
        m_flags = '0; m_condex = 1'b0; m_exec = '0; m_annul = '0;
        exp_q.push_back(model_out());
        #1;
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL reset_async: got %h expected %h", got, e);
        end
        exp_q.push_back(model_out());
        @(negedge clk);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL reset_hold: got %h expected %h", got, e);
        end
        reset = 1'b1;
        step(4'd0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        got = observed(); e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin
            n_err++; $display("FAIL reset_resume: got %h expected %h", got, e);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_annul_eq();
        test_flag_exec();
        test_write_gating();
        test_cond_table();
        test_same_cycle();
        test_saturate();
        test_reset_mid_exec();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
